// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding selects and load-use stall detection for the EX stage.
// Tracks its own ID/EX, EX/MEM and MEM/WB register metadata.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count
);

    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_rw;
    logic                  r_ex_mr;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_rw;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_rw;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_mem_ok;
    logic w_wb_ok;
    logic w_mem_a;
    logic w_mem_b;
    logic w_wb_a;
    logic w_wb_b;
    logic w_ex_load;
    logic w_stall;
    logic w_take_id;

    // x0 is hardwired zero, so a write to it never produces a value
    assign w_mem_ok = r_mem_rw && (r_mem_rd != '0);
    assign w_wb_ok  = r_wb_rw && (r_wb_rd != '0);
    assign w_mem_a  = w_mem_ok && (r_mem_rd == r_ex_rs1);
    assign w_mem_b  = w_mem_ok && (r_mem_rd == r_ex_rs2);
    assign w_wb_a   = w_wb_ok && (r_wb_rd == r_ex_rs1);
    assign w_wb_b   = w_wb_ok && (r_wb_rd == r_ex_rs2);

    always_comb begin
        forward_a = 2'b00;
        if (w_mem_a) begin
            forward_a = 2'b10;
        end else if (w_wb_a) begin
            forward_a = 2'b01;
        end
    end

    always_comb begin
        forward_b = 2'b00;
        if (w_mem_b) begin
            forward_b = 2'b10;
        end else if (w_wb_b) begin
            forward_b = 2'b01;
        end
    end

    assign w_ex_load = r_ex_mr && (r_ex_rd != '0);
    assign w_stall   = id_valid && w_ex_load && !flush &&
                       ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
    assign w_take_id = id_valid && !w_stall && !flush;

    assign stall       = w_stall;
    assign bubble      = w_stall || flush;
    assign stall_count = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_rw    <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_rw     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_wb_rd  <= r_mem_rd;
            r_wb_rw  <= r_mem_rw;
            r_mem_rd <= r_ex_rd;
            r_mem_rw <= r_ex_rw;
            if (w_take_id) begin
                r_ex_rs1 <= id_rs1;
                r_ex_rs2 <= id_rs2;
                r_ex_rd  <= id_rd;
                r_ex_rw  <= id_reg_write;
                r_ex_mr  <= id_mem_read;
            end else begin
                r_ex_rs1 <= '0;
                r_ex_rs2 <= '0;
                r_ex_rd  <= '0;
                r_ex_rw  <= 1'b0;
                r_ex_mr  <= 1'b0;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
